coeff_block_assembler: RTL and testbench

//  Producer end of the IDCT block interface: turns the entropy decoder's serial (run, coefficient)

---
 rtl/coeff_block_assembler.sv | 109 ++++++++++
 tb/tb_coeff_block_assembler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_block_assembler.sv
// Assembles serial (run, coef, eob) entries into one de-zigzagged 8x8 block, row-major, 64*COEF_W bits wide.
// Latency: block word and m_valid register on the completing accept edge; no backpressure, in_ready drops for the one EMIT cycle.
module coeff_block_assembler #(
    parameter int COEF_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_run,
    input  logic [COEF_W-1:0]    in_coef,
    input  logic                 in_eob,
    output logic [64*COEF_W-1:0] data_out,
    output logic                 m_valid,
    output logic                 err
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // zigzag scan position -> natural (row*8+col) index
    localparam int DZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    state_t                r_state;
    state_t                w_state_nxt;
    logic [6:0]            r_pos;
    logic [64*COEF_W-1:0]  r_work;
    logic [64*COEF_W-1:0]  w_merged;
    logic [6:0]            w_tgt;
    logic [5:0]            w_nat;
    logic                  w_accept;
    logic                  w_over;
    logic                  w_done;

    // pos never exceeds 63 while filling, so pos+run stays within 7 bits
    assign w_accept = in_valid && (r_state == S_FILL);
    assign w_tgt    = r_pos + {3'b000, in_run};
    assign w_over   = (w_tgt > 7'd63);
    assign w_nat    = 6'(DZZ[w_tgt[5:0]]);
    assign w_done   = w_accept && (w_over || in_eob || (w_tgt == 7'd63));

    always_comb begin
        w_merged = r_work;
        if (!w_over) begin
            w_merged[int'(w_nat)*COEF_W +: COEF_W] = in_coef;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = 1'b1;
                if (w_done) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_state_nxt = S_FILL;
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // The completing write goes straight into data_out; work is cleared for the next block at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pos    <= '0;
            r_work   <= '0;
            data_out <= '0;
            m_valid  <= 1'b0;
            err      <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            err     <= 1'b0;
            if (w_accept) begin
                if (w_done) begin
                    data_out <= w_merged;
                    m_valid  <= 1'b1;
                    err      <= w_over;
                    r_work   <= '0;
                    r_pos    <= '0;
                end else begin
                    r_work <= w_merged;
                    r_pos  <= w_tgt + 7'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_coeff_block_assembler.sv
// Bench for coeff_block_assembler: vector table of single-entry blocks, hand-written corner sequences,
// and randomized blocks against a scan-order model of the block.
module tb_coeff_block_assembler;

    localparam int CW = 32;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_run;
    logic [CW-1:0]    in_coef;
    logic             in_eob;
    logic [64*CW-1:0] data_out;
    logic             m_valid;
    logic             err;

    coeff_block_assembler #(.COEF_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_run   (in_run),
        .in_coef  (in_coef),
        .in_eob   (in_eob),
        .data_out (data_out),
        .m_valid  (m_valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // reference model: block in natural order, scan position, last emitted block
    logic [31:0] m_blk [64];
    logic [31:0] m_out [64];
    int          m_pos;
    bit          m_ready;
    bit          e_mv;
    bit          e_err;
    bit          blk_done;

    int cyc;
    int last_mv;
    int gap;
    int mv_count;
    int nrdy_count;

    typedef struct {
        int          run;
        logic [31:0] coef;
        int          idx;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_data(input string nm);
        int bad = -1;
        for (int k = 0; k < 64; k++) begin
            if (bad < 0 && data_out[32*k +: 32] !== m_out[k]) bad = k;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s word%0d actual=%h required=%h (t=%0t)", nm, bad,
                     data_out[32*bad +: 32], m_out[bad], $time);
        end
    endtask

    function automatic int nz_except(input int idx);
        int n = 0;
        for (int k = 0; k < 64; k++) begin
            if (k != idx && data_out[32*k +: 32] != 32'd0) n++;
        end
        return n;
    endfunction

    task automatic model_reset();
        m_blk   = '{default: 32'd0};
        m_out   = '{default: 32'd0};
        m_pos   = 0;
        m_ready = 1'b1;
    endtask

    // one clock cycle: drive after negedge, check after posedge, return at next negedge
    task automatic step(input bit v, input int run, input logic [31:0] coef, input bit eob);
        bit acc;
        int tgt;
        in_valid = v;
        in_run   = 4'(run);
        in_coef  = coef;
        in_eob   = eob;
        #1;
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_ready});
        if (!in_ready) nrdy_count++;
        acc      = v && m_ready;
        e_mv     = 1'b0;
        e_err    = 1'b0;
        blk_done = 1'b0;
        if (acc) begin
            tgt = m_pos + run;
            if (tgt > 63) begin
                e_err    = 1'b1;
                blk_done = 1'b1;
            end else begin
                m_blk[ZZ[tgt]] = coef;
                m_pos    = tgt + 1;
                blk_done = eob || (tgt == 63);
            end
            if (blk_done) begin
                e_mv  = 1'b1;
                m_out = m_blk;
                m_blk = '{default: 32'd0};
                m_pos = 0;
            end
        end
        m_ready = !blk_done;
        @(posedge clk);
        #1;
        cyc++;
        chk("m_valid", {31'd0, m_valid}, {31'd0, e_mv});
        chk("err", {31'd0, err}, {31'd0, e_err});
        check_data("data_out");
        if (m_valid) begin
            mv_count++;
            if (last_mv >= 0) gap = cyc - last_mv;
            last_mv = cyc;
        end
        @(negedge clk);
    endtask

    // offer one entry with valid held until accepted (at most one EMIT cycle in the way)
    task automatic send(input int run, input logic [31:0] coef, input bit eob);
        if (!m_ready) step(1'b1, run, coef, eob);
        step(1'b1, run, coef, eob);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int run;
        int n;
        clk      = 1'b0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_run   = '0;
        in_coef  = '0;
        in_eob   = 1'b0;
        cyc      = 0;
        last_mv  = -1;
        gap      = 0;
        mv_count = 0;
        nrdy_count = 0;
        model_reset();

        tbl[0] = '{0,  32'd100,        0};
        tbl[1] = '{0,  32'd0,          0};
        tbl[2] = '{1,  32'hFFFF_FFF9,  1};
        tbl[3] = '{2,  32'd12345,      8};
        tbl[4] = '{3,  32'h7FFF_FFFF, 16};
        tbl[5] = '{5,  32'hFFFF_FFFF,  2};
        tbl[6] = '{9,  32'd42,        24};
        tbl[7] = '{15, 32'h8000_0000,  5};

        #13;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_data("rst_data_out");
        @(negedge clk);
        rst = 1'b1;

        // single-entry blocks: one coefficient at dzz(run)
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].run, tbl[i].coef, 1'b1);
            chk("tbl_m_valid", {31'd0, m_valid}, 32'd1);
            chk("tbl_word", data_out[32*tbl[i].idx +: 32], tbl[i].coef);
            chk("tbl_zeros", nz_except(tbl[i].idx), 32'd0);
        end
        step(1'b0, 0, 32'd0, 1'b0);

        // full block, no eob, valid held
        nrdy_count = 0;
        mv_count   = 0;
        for (int z = 0; z < 64; z++) send(0, z, 1'b0);
        chk("full_word1", data_out[32*1 +: 32], 32'd1);
        chk("full_word8", data_out[32*8 +: 32], 32'd2);
        chk("full_word16", data_out[32*16 +: 32], 32'd3);
        chk("full_word63", data_out[32*63 +: 32], 32'd63);
        step(1'b0, 0, 32'd0, 1'b0);
        chk("full_mv_count", mv_count, 32'd1);
        chk("full_nrdy", nrdy_count, 32'd1);

        // overrun at 60 + 5
        for (int z = 0; z < 60; z++) send(0, 32'd1, 1'b0);
        send(5, 32'd7, 1'b0);
        chk("ovr_err", {31'd0, err}, 32'd1);
        chk("ovr_m_valid", {31'd0, m_valid}, 32'd1);
        chk("ovr_zz60", data_out[32*47 +: 32], 32'd0);
        chk("ovr_zz61", data_out[32*55 +: 32], 32'd0);
        chk("ovr_zz62", data_out[32*62 +: 32], 32'd0);
        chk("ovr_zz63", data_out[32*63 +: 32], 32'd0);
        chk("ovr_zz59", data_out[32*54 +: 32], 32'd1);
        step(1'b0, 0, 32'd0, 1'b0);

        // asynchronous reset with a partial block pending
        for (int z = 0; z < 10; z++) send(0, z + 11, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("mrst_err", {31'd0, err}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_data_zero", nz_except(-1), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send(0, 32'd100, 1'b1);
        chk("mrst_dc_word0", data_out[31:0], 32'd100);
        chk("mrst_no_stale", nz_except(0), 32'd0);
        step(1'b0, 0, 32'd0, 1'b0);

        // skip pattern, two blocks back to back with valid continuous
        last_mv = -1;
        send(0, 32'd5, 1'b0);
        send(2, 32'hFFFF_FFFD, 1'b1);
        chk("skip_word0", data_out[31:0], 32'd5);
        chk("skip_word16", data_out[32*16 +: 32], 32'hFFFF_FFFD);
        chk("skip_zeros", nz_except(0) - ((data_out[32*16 +: 32] != 0) ? 1 : 0), 32'd0);
        send(0, 32'd5, 1'b0);
        send(2, 32'hFFFF_FFFD, 1'b1);
        chk("b2b_gap", gap, 32'd3);
        chk("b2b_word0", data_out[31:0], 32'd5);
        chk("b2b_word16", data_out[32*16 +: 32], 32'hFFFF_FFFD);
        step(1'b0, 0, 32'd0, 1'b0);

        // randomized blocks with idle gaps
        for (int b = 0; b < 40; b++) begin
            blk_done = 1'b0;
            n = 0;
            while (!blk_done && n < 200) begin
                if ($urandom_range(0, 3) == 0)
                    step(1'b0, $urandom_range(0, 15), $urandom, 1'($urandom_range(0, 1)));
                run = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
                send(run, $urandom, ($urandom_range(0, 19) == 0));
                n++;
            end
        end
        step(1'b0, 0, 32'd0, 1'b0);
        step(1'b0, 0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
